// File: rtl/pad_attr_cfg_pkg.sv
// rtl/pad_attr_cfg_pkg.sv - shared types and constants for the pad attribute config controller
// Contents: FSM state enum, latched-request struct (sized for the widest
// supported configuration), and the lock-bit position helper.
package pad_attr_cfg_pkg;

    // Upper bounds for the latched-request fields; instances narrower than
    // these zero-extend into the struct.
    localparam int ATTR_W_MAX = 64;
    localparam int IDX_W_MAX  = 8;
    localparam int REQ_W_MAX  = 8;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        RESP,
        SETTLE
    } pad_attr_state_e;

    typedef struct packed {
        logic                  write;
        logic [IDX_W_MAX-1:0]  idx;
        logic [ATTR_W_MAX-1:0] attr;
        logic [REQ_W_MAX-1:0]  winner;
    } pad_attr_req_t;

    // The lock request travels in the top attribute bit.
    function automatic int pad_attr_lock_bit(input int attr_w);
        return attr_w - 1;
    endfunction

endpackage

// File: rtl/pad_attr_rr_arb.sv
// rtl/pad_attr_rr_arb.sv - combinational round-robin winner select
// Ports: valid  - request vector
//        ptr    - highest-priority requester index
//        grant  - one-hot grant (zero when nothing valid)
//        winner - index of the granted requester
//        any    - at least one request valid
module pad_attr_rr_arb #(
    parameter int NumReq = 4,
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] valid,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] grant,
    output logic [IdxW-1:0]   winner,
    output logic              any
);

    // Scan offsets 0..NumReq-1 from the pointer; the first valid hit wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int off = 0; off < NumReq; off++) begin
            for (int j = 0; j < NumReq; j++) begin
                if (!any && valid[j] && (j == (int'(ptr) + off) % NumReq)) begin
                    any      = 1'b1;
                    grant[j] = 1'b1;
                    winner   = IdxW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/pad_attr_cfg_ctrl.sv
// rtl/pad_attr_cfg_ctrl.sv - arbitrated, WARL-masked pad attribute register bank with settle gap
// Optional build macro: PAD_ATTR_LOCK_EN (per-pad sticky lock via attribute bit AttrW-1).
// Ports: clk_i/rst_i          - clock, synchronous active-high reset
//        req_valid/ready/write/pad/attr - per-requester request channel (packed)
//        warl_mask_i          - supported attribute bits
//        rsp_valid_o/attr/err - one-cycle response to the granted requester
//        pad_attr_o           - current attribute per pad (packed)
//        pad_attr_upd_o       - per-pad write strobe, aligned with the response
//        busy_o               - controller not in IDLE
module pad_attr_cfg_ctrl
    import pad_attr_cfg_pkg::*;
#(
    parameter int NumReq       = 4,
    parameter int NumPads      = 8,
    parameter int AttrW        = 32,
    parameter int SettleCycles = 3,
    parameter int PadIdxW      = $clog2(NumPads + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_valid_i,
    output logic [NumReq-1:0]         req_ready_o,
    input  logic [NumReq-1:0]         req_write_i,
    input  logic [NumReq*PadIdxW-1:0] req_pad_i,
    input  logic [NumReq*AttrW-1:0]   req_attr_i,
    input  logic [AttrW-1:0]          warl_mask_i,
    output logic [NumReq-1:0]         rsp_valid_o,
    output logic [AttrW-1:0]          rsp_attr_o,
    output logic                      rsp_err_o,
    output logic [NumPads*AttrW-1:0]  pad_attr_o,
    output logic [NumPads-1:0]        pad_attr_upd_o,
    output logic                      busy_o
);

    localparam int ReqIdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW    = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam bit HasSettle = (SettleCycles > 0);
    localparam logic [CntW-1:0] SettleLoad = HasSettle ? CntW'(SettleCycles - 1) : '0;

    pad_attr_state_e    state_q;
    pad_attr_req_t      req_q;
    logic [ReqIdxW-1:0] ptr_q;
    logic [CntW-1:0]    cnt_q;
    logic [AttrW-1:0]   pad_q [NumPads];

`ifdef PAD_ATTR_LOCK_EN
    localparam int PAD_ATTR_LOCK_BIT = pad_attr_lock_bit(AttrW);
    logic [NumPads-1:0] lock_q;
    logic               cur_lock;
`endif

    logic [NumReq-1:0]  grant;
    logic [ReqIdxW-1:0] winner;
    logic               grant_any;

    logic               sel_write;
    logic [PadIdxW-1:0] sel_pad;
    logic [AttrW-1:0]   sel_attr;

    logic [AttrW-1:0]   cur_attr;
    logic [AttrW-1:0]   masked;
    logic [AttrW-1:0]   new_attr;
    logic               idx_ok;
    logic               apply_err;
    logic               apply_wr;

    pad_attr_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (ReqIdxW)
    ) u_arb (
        .valid  (req_valid_i),
        .ptr    (ptr_q),
        .grant  (grant),
        .winner (winner),
        .any    (grant_any)
    );

    // Ready is the grant itself, only offered in IDLE and never during reset.
    assign req_ready_o = (state_q == IDLE && !rst_i) ? grant : '0;
    assign busy_o      = (state_q != IDLE);

    for (genvar p = 0; p < NumPads; p++) begin : g_pad_out
        assign pad_attr_o[p*AttrW +: AttrW] = pad_q[p];
    end

    // Payload mux of the granted requester.
    always_comb begin
        sel_write = 1'b0;
        sel_pad   = '0;
        sel_attr  = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant[i]) begin
                sel_write = req_write_i[i];
                sel_pad   = req_pad_i[i*PadIdxW +: PadIdxW];
                sel_attr  = req_attr_i[i*AttrW +: AttrW];
            end
        end
    end

    // APPLY decision: range check (and lock check), masked write value and
    // the post-write value returned in the response.
    always_comb begin
        cur_attr = '0;
        idx_ok   = 1'b0;
`ifdef PAD_ATTR_LOCK_EN
        cur_lock = 1'b0;
`endif
        for (int p = 0; p < NumPads; p++) begin
            if (req_q.idx == IDX_W_MAX'(p)) begin
                cur_attr = pad_q[p];
                idx_ok   = 1'b1;
`ifdef PAD_ATTR_LOCK_EN
                cur_lock = lock_q[p];
`endif
            end
        end
        masked = AttrW'(req_q.attr & ATTR_W_MAX'(warl_mask_i));
`ifdef PAD_ATTR_LOCK_EN
        // The lock request bit is consumed, never stored.
        masked[PAD_ATTR_LOCK_BIT] = 1'b0;
        apply_err = !idx_ok || (req_q.write && cur_lock);
`else
        apply_err = !idx_ok;
`endif
        apply_wr = req_q.write && !apply_err;
        new_attr = apply_wr ? masked : cur_attr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            req_q          <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            rsp_valid_o    <= '0;
            rsp_attr_o     <= '0;
            rsp_err_o      <= 1'b0;
            pad_attr_upd_o <= '0;
            for (int p = 0; p < NumPads; p++) begin
                pad_q[p] <= '0;
            end
`ifdef PAD_ATTR_LOCK_EN
            lock_q <= '0;
`endif
        end else begin
            rsp_valid_o    <= '0;
            rsp_attr_o     <= '0;
            rsp_err_o      <= 1'b0;
            pad_attr_upd_o <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        req_q <= '{write:  sel_write,
                                   idx:    IDX_W_MAX'(sel_pad),
                                   attr:   ATTR_W_MAX'(sel_attr),
                                   winner: REQ_W_MAX'(winner)};
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    for (int p = 0; p < NumPads; p++) begin
                        if (apply_wr && req_q.idx == IDX_W_MAX'(p)) begin
                            pad_q[p]          <= masked;
                            pad_attr_upd_o[p] <= 1'b1;
`ifdef PAD_ATTR_LOCK_EN
                            if (req_q.attr[PAD_ATTR_LOCK_BIT]) begin
                                lock_q[p] <= 1'b1;
                            end
`endif
                        end
                    end
                    for (int i = 0; i < NumReq; i++) begin
                        rsp_valid_o[i] <= (req_q.winner == REQ_W_MAX'(i));
                    end
                    rsp_attr_o <= apply_err ? '0 : new_attr;
                    rsp_err_o  <= apply_err;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (req_q.winner == REQ_W_MAX'(NumReq - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= ReqIdxW'(req_q.winner + REQ_W_MAX'(1));
                    end
                    // A successful write is exactly the case that raised a strobe.
                    if (HasSettle && (|pad_attr_upd_o)) begin
                        cnt_q   <= SettleLoad;
                        state_q <= SETTLE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pad_attr_cfg_ctrl.md
Name: pad_attr_cfg_ctrl

Overview:
- Sequences run-time pad attribute programming for a bank of pads whose supported-attribute mask comes from the pad attribute primitive hierarchy (`prim_pad_attr` and below).
- Several software and hardware requesters share one attribute register bank through a round-robin arbiter.
- Written values are WARL-masked against the supported mask.
- A programmable settle interval is enforced after every successful write before the next grant.

Parameters:
- NumReq, 4, number of requesters (>=1).
- NumPads, 8, number of pad attribute registers (>=1).
- AttrW, 32, attribute word width; matches the primitive's mask width.
- SettleCycles, 3, idle cycles inserted after a successful write (0 = none).
- PadIdxW, $clog2(NumPads+1), width of the pad index; one extra code exists so out-of-range indices are testable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester accept; one-hot or zero
- req_write_i  in  NumReq  1 = write, 0 = read
- req_pad_i  in  NumReq*PadIdxW  target pad index, packed per requester
- req_attr_i  in  NumReq*AttrW  write data, packed per requester
- warl_mask_i  in  AttrW  supported attribute bits from the pad attribute primitive
- rsp_valid_o  out  NumReq  one-cycle response pulse to the granted requester
- rsp_attr_o  out  AttrW  response data, shared by all requesters
- rsp_err_o  out  1  error flag qualified by any rsp_valid_o bit
- pad_attr_o  out  NumPads*AttrW  current attribute per pad
- pad_attr_upd_o  out  NumPads  one-cycle strobe when a pad's value is written
- busy_o  out  1  high whenever state != IDLE

Behaviour:

Reset:
- All pad_attr_o = 0; all strobes, rsp_* and req_ready_o = 0.
- state = IDLE; round-robin pointer = 0; settle counter = 0.

FSM: IDLE -> APPLY -> RESP -> (SETTLE | IDLE).
- IDLE:
  - Winner = first valid requester at or after the pointer, wrapping modulo NumReq.
  - req_ready_o[winner] = 1 in the same cycle; this is the accept cycle.
  - Write flag, index and data are latched; go to APPLY.
  - With no valid requests, stay in IDLE.
- APPLY:
  - Index >= NumPads: error, no state change.
  - Valid write: pad[idx] <= req_attr & warl_mask_i (mask sampled this cycle); pad_attr_upd_o[idx] pulses in the next cycle, aligned with RESP.
  - Read: no change.
- RESP:
  - rsp_valid_o[winner] = 1 for exactly one cycle.
  - rsp_attr_o = pad[idx] after the write; 0 on error.
  - rsp_err_o as decided in APPLY.
  - Pointer <= winner+1, wrapping NumReq-1 -> 0.
  - Next state is SETTLE if a successful write occurred and SettleCycles > 0, else IDLE.
- SETTLE: counter loads SettleCycles-1 on entry and decrements; return to IDLE when it reaches 0. No grants are issued during SETTLE.

Timing:
- Latency from accept to response is 2 cycles.
- Minimum spacing between accepts is 3 cycles, or 3+SettleCycles after a successful write.

Handshake rules:
- Requesters hold valid and payload stable until ready.
- Deasserting valid before ready is permitted; the request is simply not taken.
- Outside IDLE, req_ready_o = 0 regardless of req_valid_i.

Simultaneous events:
- Only one requester is granted per accept.
- Losers keep valid and are served in pointer order.
- Reset asserted in any state returns to reset values on the next edge.
- A transaction cut off by reset produces no response and no strobe.

Optional Feature:
- PAD_ATTR_LOCK_EN defined:
  - Adds a per-pad sticky lock bit.
  - A successful write with req_attr[AttrW-1] = 1 sets the lock after the write; bit AttrW-1 is not stored.
  - Later writes to a locked pad return rsp_err_o = 1 and change nothing.
  - Reads are unaffected. Locks clear only on rst_i.
- PAD_ATTR_LOCK_EN undefined: no lock state; bit AttrW-1 is an ordinary attribute bit subject to warl_mask_i.

Decomposition:
- Package pad_attr_cfg_pkg holds:
  - the state enum {IDLE, APPLY, RESP, SETTLE};
  - a latched-request struct {write, idx, attr, winner};
  - the constant PAD_ATTR_LOCK_BIT = AttrW-1 convention.
- One sub-module, pad_attr_rr_arb: combinational winner select from a valid vector and a pointer, outputting a one-hot grant and the winner index.
- Pointer register stays in pad_attr_cfg_ctrl.

Test Plan:
- Basic write: mask 0x0000_00FF; req0 writes pad2 = 0x1234_56AB -> ready0 in cycle 0; rsp_valid[0] in cycle 2 with rsp_attr = 0x0000_00AB and err = 0; pad_attr_upd_o[2] pulses in cycle 2; busy_o held through 3 SETTLE cycles.
- Round-robin: req0..req3 all valid continuously, reads only -> grants in order 0, 1, 2, 3, 0; accepts every 3 cycles.
- Out-of-range index: req1 writes pad 8 with NumPads = 8 -> rsp_err_o = 1, rsp_attr_o = 0, no strobe, no SETTLE.
- Read after write: req2 writes pad5 = 0xA5 with mask 0xFF, then req3 reads pad5 -> rsp_attr_o = 0xA5; the read is not granted until 3 SETTLE cycles have elapsed.
- Reset mid-operation: rst_i asserted in APPLY of a pad0 write -> pad0 = 0, no rsp_valid_o, pointer = 0, state IDLE on the next cycle.
- Lock (PAD_ATTR_LOCK_EN): write pad1 = 0x8000_0003 with mask all-ones, then write pad1 = 0x5 -> second response has err = 1 and pad1 stays 0x0000_0003.
